// File: rtl/board_seeder_if.sv
// rtl/board_seeder_if.sv - fill request/stall inputs and cell-RAM write bus of the board seeder
interface board_seeder_if #(
  parameter int ADDR_W = 24
);
  logic              start;
  logic [1:0]        mode;
  logic              hold;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  // seeder side: takes fill requests and stalls, drives the RAM write port
  modport master (
    input  start, mode, hold,
    output busy, done, wr_en, wr_addr, wr_data
  );

  // requester / RAM side
  modport slave (
    output start, mode, hold,
    input  busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/board_seeder.sv
// rtl/board_seeder.sv - writes one full Game of Life generation (clear/random/checker) into the cell RAM
module board_seeder #(
  parameter int          P_N     = 400,
  parameter int          P_M     = 300,
  parameter int          ADDR_W  = 24,
  parameter logic [31:0] SEED    = 32'hACE1_1234,
  parameter int          DENSITY = 64
) (
  input  logic           clk_vga,
  input  logic           reset_btn,
  board_seeder_if.master bus
);

  localparam int          COL_W     = $clog2(P_N);
  localparam int          ROW_W     = $clog2(P_M);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // an all-zero Galois LFSR never leaves zero, so a zero seed is replaced
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [8:0]  DENS9     = 9'(DENSITY);

  localparam logic [1:0] MODE_RANDOM  = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic                prev_start_q;
  logic [31:0]         lfsr_q, lfsr_d;

  logic                start_edge;
  logic                last_col;
  logic                last_row;
  logic                rnd_d;
  logic [COL_W-1:0]    next_col;
  logic [ROW_W-1:0]    next_row;

  // value of a cell given the latched mode; mode 3 falls through to clear
  function automatic logic cell_value(input logic [1:0] m, input logic row0,
                                      input logic col0, input logic rnd);
    logic v;
    case (m)
      MODE_RANDOM:  v = rnd;
      MODE_CHECKER: v = row0 ^ col0;
      default:      v = 1'b0;
    endcase
    return v;
  endfunction

  // LFSR step and the random draw for whichever cell is presented next cycle
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    // the draw uses the LFSR value that is current while the new cell is on the bus
    rnd_d  = ({1'b0, lfsr_d[7:0]} < DENS9);
  end

  // raster position bookkeeping: row/col wrap and end-of-board detection
  always_comb begin
    start_edge = bus.start & ~prev_start_q;
    last_col   = (col_q == COL_W'(P_N - 1));
    last_row   = (row_q == ROW_W'(P_M - 1));
    next_col   = last_col ? '0 : col_q + COL_W'(1);
    next_row   = last_col ? row_q + ROW_W'(1) : row_q;
  end

  // next-state logic: IDLE waits for a start edge, FILL walks the board, DONE pulses once
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          mode_d  = bus.mode;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          data_d  = cell_value(bus.mode, 1'b0, 1'b0, rnd_d);
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        // a held cycle keeps address, data and counters; only the LFSR moves on
        if (!bus.hold) begin
          if (last_col && last_row) begin
            state_d = S_DONE;
          end else begin
            col_d  = next_col;
            row_d  = next_row;
            addr_d = addr_q + ADDR_W'(1);
            data_d = cell_value(mode_q, next_row[0], next_col[0], rnd_d);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers; reset_btn aborts a fill at once
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      data_q       <= 1'b0;
      mode_q       <= 2'd0;
      prev_start_q <= 1'b0;
      lfsr_q       <= SEED_EFF;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      prev_start_q <= bus.start;
      lfsr_q       <= lfsr_d;
    end
  end

  // outputs: write enable drops combinationally with hold so a stalled cell is not written
  always_comb begin
    bus.busy    = (state_q == S_FILL);
    bus.done    = (state_q == S_DONE);
    bus.wr_en   = (state_q == S_FILL) & ~bus.hold;
    bus.wr_addr = addr_q;
    bus.wr_data = data_q;
  end

endmodule

// File: tb/tb_board_seeder.sv
// tb/tb_board_seeder.sv - randomized self-checking bench for board_seeder against a board-level model
module tb_board_seeder;

  localparam int          P_N      = 40;
  localparam int          P_M      = 30;
  localparam int          ADDR_W   = 24;
  localparam logic [31:0] SEED     = 32'hACE1_1234;
  localparam int          DENSITY  = 64;
  localparam int          TOTAL    = P_N * P_M;
  localparam int          MAXC     = 3000;
  localparam int          ABORT_AT = 600;
  localparam int          HOLD_AT  = 1000;

  logic clk_vga;
  logic reset_btn;

  board_seeder_if #(.ADDR_W(ADDR_W)) bus ();

  board_seeder #(
    .P_N(P_N), .P_M(P_M), .ADDR_W(ADDR_W), .SEED(SEED), .DENSITY(DENSITY)
  ) dut (
    .clk_vga  (clk_vga),
    .reset_btn(reset_btn),
    .bus      (bus)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  int vectors;
  int miscompares;

  // reference Galois LFSR, advanced once per clock from the reset value
  logic [31:0] model_lfsr;
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  always @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) model_lfsr <= SEED;
    else           model_lfsr <= lfsr_step(model_lfsr);
  end

  // per-cycle log of one fill, recorded while busy
  int   c_addr [MAXC];
  logic c_wen  [MAXC];
  logic c_data [MAXC];
  logic c_rnd  [MAXC];
  logic c_hold [MAXC];
  logic w_data [TOTAL];
  logic r1     [TOTAL];
  int   n_cyc;
  bit   timed_out;
  logic done_a, done_b;

  int a_writes, a_addr_err, a_data_err, a_ones, a_stall_err;

  // board rule: address -> (row, col), then alive per mode
  function automatic logic expected_cell(input logic [1:0] m, input int addr, input logic rnd);
    if (m == 2'd1) return rnd;
    if (m == 2'd2) return (((addr / P_N) + (addr % P_N)) % 2) == 1;
    return 1'b0;
  endfunction

  // reduce the cycle log to counts against the board model
  function automatic void analyse(input logic [1:0] m);
    int   prev_addr;
    logic cur_exp;
    a_writes = 0; a_addr_err = 0; a_data_err = 0; a_ones = 0; a_stall_err = 0;
    prev_addr = -1;
    cur_exp   = 1'b0;
    for (int i = 0; i < n_cyc; i++) begin
      if (c_addr[i] != prev_addr) begin
        cur_exp   = expected_cell(m, c_addr[i], c_rnd[i]);
        prev_addr = c_addr[i];
      end
      if (c_data[i] !== cur_exp) a_data_err++;
      if (c_wen[i] !== ~c_hold[i]) a_stall_err++;
      if (i + 1 < n_cyc) begin
        if (c_hold[i] && c_addr[i + 1] != c_addr[i]) a_addr_err++;
        if (!c_hold[i] && c_addr[i + 1] != c_addr[i] + 1) a_addr_err++;
      end
      if (c_wen[i] === 1'b1) begin
        if (c_addr[i] != a_writes) a_addr_err++;
        if (a_writes < TOTAL) w_data[a_writes] = c_data[i];
        if (c_data[i] === 1'b1) a_ones++;
        a_writes++;
      end
    end
  endfunction

  // request a fill and log it; optional single hold burst, random stalls, or a start re-pulse
  task automatic do_fill(input logic [1:0] m, input int hold_at, input int hold_len,
                         input bit hold_rand, input int repulse_at);
    int hold_rem;
    bit hold_used;
    @(negedge clk_vga);
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk_vga);
    @(negedge clk_vga);
    bus.mode  = 2'($urandom);
    n_cyc     = 0;
    timed_out = 1'b0;
    hold_rem  = 0;
    hold_used = 1'b0;
    while (1) begin
      bus.start = (n_cyc == repulse_at);
      if (hold_rand) begin
        bus.hold = ($urandom_range(0, 3) == 0);
      end else begin
        if (hold_rem > 0) hold_rem--;
        else if (!hold_used && hold_len > 0 && bus.wr_addr == ADDR_W'(hold_at)) begin
          hold_used = 1'b1;
          hold_rem  = hold_len;
        end
        bus.hold = (hold_rem > 0);
      end
      #1;
      if (bus.busy !== 1'b1) break;
      if (n_cyc >= MAXC) begin
        timed_out = 1'b1;
        break;
      end
      c_addr[n_cyc] = int'(bus.wr_addr);
      c_wen[n_cyc]  = bus.wr_en;
      c_data[n_cyc] = bus.wr_data;
      c_rnd[n_cyc]  = ({1'b0, model_lfsr[7:0]} < 9'(DENSITY));
      c_hold[n_cyc] = bus.hold;
      n_cyc++;
      @(negedge clk_vga);
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    done_a    = bus.done;
    @(negedge clk_vga);
    #1;
    done_b    = bus.done;
  endtask

  task automatic test_reset;
    reset_btn = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.hold  = 1'b0;
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
    vectors++; if (bus.wr_data !== 1'b0) begin miscompares++; $display("FAIL reset_wr_data: got %b expected 0", bus.wr_data); end
    @(negedge clk_vga);
    reset_btn = 1'b0;
    repeat (2) @(negedge clk_vga);
  endtask

  task automatic test_clear;
    do_fill(2'd0, -1, 0, 1'b0, -1);
    analyse(2'd0);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL clear_timeout: got %0d cycles expected %0d", n_cyc, TOTAL); end
    vectors++; if (n_cyc != TOTAL) begin miscompares++; $display("FAIL clear_busy_cycles: got %0d expected %0d", n_cyc, TOTAL); end
    vectors++; if (a_writes != TOTAL) begin miscompares++; $display("FAIL clear_writes: got %0d expected %0d", a_writes, TOTAL); end
    vectors++; if (a_addr_err != 0) begin miscompares++; $display("FAIL clear_addr_seq: got %0d bad expected 0", a_addr_err); end
    vectors++; if (a_ones != 0) begin miscompares++; $display("FAIL clear_data: got %0d live expected 0", a_ones); end
    vectors++; if (done_a !== 1'b1) begin miscompares++; $display("FAIL clear_done_pulse: got %b expected 1", done_a); end
    vectors++; if (done_b !== 1'b0) begin miscompares++; $display("FAIL clear_done_width: got %b expected 0", done_b); end
  endtask

  task automatic test_back_to_back;
    do_fill(2'd3, -1, 0, 1'b0, -1);
    analyse(2'd3);
    vectors++; if (a_writes != TOTAL || a_addr_err != 0) begin miscompares++; $display("FAIL b2b_mode3_writes: got %0d/%0d bad expected %0d/0", a_writes, a_addr_err, TOTAL); end
    vectors++; if (a_data_err != 0) begin miscompares++; $display("FAIL b2b_mode3_data: got %0d bad expected 0", a_data_err); end
    do_fill(2'd2, -1, 0, 1'b0, -1);
    analyse(2'd2);
    vectors++; if (n_cyc != TOTAL || done_a !== 1'b1) begin miscompares++; $display("FAIL b2b_second_fill: got %0d cycles done=%b expected %0d done=1", n_cyc, done_a, TOTAL); end
  endtask

  task automatic test_checker;
    do_fill(2'd2, -1, 0, 1'b0, -1);
    analyse(2'd2);
    vectors++; if (a_data_err != 0 || a_addr_err != 0) begin miscompares++; $display("FAIL checker_stream: got %0d data/%0d addr bad expected 0", a_data_err, a_addr_err); end
    vectors++; if (w_data[0] !== 1'b0) begin miscompares++; $display("FAIL checker_addr0: got %b expected 0", w_data[0]); end
    vectors++; if (w_data[1] !== 1'b1) begin miscompares++; $display("FAIL checker_addr1: got %b expected 1", w_data[1]); end
    vectors++; if (w_data[P_N-1] !== 1'b1) begin miscompares++; $display("FAIL checker_row0_last: got %b expected 1", w_data[P_N-1]); end
    vectors++; if (w_data[P_N] !== 1'b1) begin miscompares++; $display("FAIL checker_row1_col0: got %b expected 1", w_data[P_N]); end
    vectors++; if (w_data[P_N+1] !== 1'b0) begin miscompares++; $display("FAIL checker_row1_col1: got %b expected 0", w_data[P_N+1]); end
  endtask

  task automatic test_random;
    int diffs;
    do_fill(2'd1, -1, 0, 1'b0, -1);
    analyse(2'd1);
    for (int i = 0; i < TOTAL; i++) r1[i] = w_data[i];
    vectors++; if (a_writes != TOTAL || a_data_err != 0) begin miscompares++; $display("FAIL random1_model: got %0d writes %0d bad expected %0d/0", a_writes, a_data_err, TOTAL); end
    vectors++; if (a_ones < TOTAL/5 || a_ones > (TOTAL*3)/10) begin miscompares++; $display("FAIL random1_density: got %0d live expected %0d..%0d", a_ones, TOTAL/5, (TOTAL*3)/10); end
    do_fill(2'd1, -1, 0, 1'b0, -1);
    analyse(2'd1);
    vectors++; if (a_data_err != 0) begin miscompares++; $display("FAIL random2_model: got %0d bad expected 0", a_data_err); end
    diffs = 0;
    for (int i = 0; i < TOTAL; i++) if (r1[i] !== w_data[i]) diffs++;
    vectors++; if (diffs == 0) begin miscompares++; $display("FAIL random_fills_differ: got %0d differing cells expected >0", diffs); end
  endtask

  task automatic test_hold;
    int n_at, w_at, d_bad;
    do_fill(2'd1, HOLD_AT, 5, 1'b0, -1);
    analyse(2'd1);
    n_at = 0; w_at = 0; d_bad = 0;
    for (int i = 0; i < n_cyc; i++) begin
      if (c_addr[i] == HOLD_AT) begin
        n_at++;
        if (c_wen[i] === 1'b1) w_at++;
        if (c_data[i] !== c_data[i-1+ (n_at == 1 ? 1 : 0)]) d_bad++;
      end
    end
    vectors++; if (n_cyc != TOTAL + 5) begin miscompares++; $display("FAIL hold_busy_cycles: got %0d expected %0d", n_cyc, TOTAL + 5); end
    vectors++; if (n_at != 6) begin miscompares++; $display("FAIL hold_addr_stays: got %0d cycles at %0d expected 6", n_at, HOLD_AT); end
    vectors++; if (w_at != 1) begin miscompares++; $display("FAIL hold_single_write: got %0d writes expected 1", w_at); end
    vectors++; if (d_bad != 0) begin miscompares++; $display("FAIL hold_data_frozen: got %0d changes expected 0", d_bad); end
    vectors++; if (a_writes != TOTAL || a_addr_err != 0 || a_data_err != 0 || a_stall_err != 0) begin miscompares++; $display("FAIL hold_stream: got %0d writes %0d/%0d/%0d bad expected %0d/0/0/0", a_writes, a_addr_err, a_data_err, a_stall_err, TOTAL); end
  endtask

  task automatic test_random_stalls;
    int holds;
    do_fill(2'd1, -1, 0, 1'b1, -1);
    analyse(2'd1);
    holds = 0;
    for (int i = 0; i < n_cyc; i++) if (c_hold[i] === 1'b1) holds++;
    vectors++; if (timed_out || n_cyc != TOTAL + holds) begin miscompares++; $display("FAIL stalls_length: got %0d expected %0d", n_cyc, TOTAL + holds); end
    vectors++; if (a_writes != TOTAL || a_addr_err != 0 || a_data_err != 0 || a_stall_err != 0) begin miscompares++; $display("FAIL stalls_stream: got %0d writes %0d/%0d/%0d bad expected %0d/0/0/0", a_writes, a_addr_err, a_data_err, a_stall_err, TOTAL); end
    vectors++; if (done_a !== 1'b1 || done_b !== 1'b0) begin miscompares++; $display("FAIL stalls_done: got %b%b expected 10", done_a, done_b); end
  endtask

  task automatic test_repulse;
    int busy_after;
    do_fill(2'd0, -1, 0, 1'b0, int'($urandom_range(TOTAL - 20, 5)));
    analyse(2'd0);
    vectors++; if (n_cyc != TOTAL || a_addr_err != 0) begin miscompares++; $display("FAIL repulse_no_restart: got %0d cycles %0d bad expected %0d/0", n_cyc, a_addr_err, TOTAL); end
    vectors++; if (done_a !== 1'b1 || done_b !== 1'b0) begin miscompares++; $display("FAIL repulse_done: got %b%b expected 10", done_a, done_b); end
    busy_after = 0;
    repeat (5) begin @(negedge clk_vga); #1; if (bus.busy === 1'b1) busy_after++; end
    vectors++; if (busy_after != 0) begin miscompares++; $display("FAIL repulse_no_second_fill: got %0d busy cycles expected 0", busy_after); end
  endtask

  task automatic test_abort;
    int waited, dones, busys;
    @(negedge clk_vga);
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    @(posedge clk_vga);
    @(negedge clk_vga);
    bus.start = 1'b0;
    waited = 0;
    while (bus.wr_addr != ADDR_W'(ABORT_AT) && waited < MAXC) begin
      @(negedge clk_vga);
      waited++;
    end
    vectors++; if (waited >= MAXC) begin miscompares++; $display("FAIL abort_reach_addr: got %0d expected %0d", bus.wr_addr, ABORT_AT); end
    #2 reset_btn = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_async_ctrl: got busy=%b wr_en=%b done=%b expected 000", bus.busy, bus.wr_en, bus.done); end
    vectors++; if (bus.wr_addr !== '0) begin miscompares++; $display("FAIL abort_async_addr: got %0d expected 0", bus.wr_addr); end
    @(posedge clk_vga);
    @(negedge clk_vga);
    reset_btn = 1'b0;
    dones = 0; busys = 0;
    repeat (20) begin @(negedge clk_vga); #1; if (bus.done === 1'b1) dones++; if (bus.busy === 1'b1) busys++; end
    vectors++; if (dones != 0 || busys != 0) begin miscompares++; $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0/0", dones, busys); end
    do_fill(2'd1, -1, 0, 1'b0, -1);
    analyse(2'd1);
    vectors++; if (n_cyc < 1 || c_addr[0] != 0 || a_writes != TOTAL || a_data_err != 0) begin miscompares++; $display("FAIL abort_refill: got first=%0d writes=%0d bad=%0d expected 0/%0d/0", c_addr[0], a_writes, a_data_err, TOTAL); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_clear();
    test_back_to_back();
    test_checker();
    test_random();
    test_hold();
    test_random_stalls();
    test_repulse();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
